huff_pack_ctrl: RTL
===================

// Module: huff_pack_ctrl
// PURPOSE
//  Sequencer for the Huffman bit packer (concat). Takes a valid/ready stream of
//  {code,len,last} codewords, issues start/din/len/last to the packer under its
//  busy/last rules, and captures packed words into a FIFO. The FIFO drives a
//  valid/ready output with end-of-frame tag and tail bit count. Sits between the
//  codebook lookup and the byte-stuffing/output stage.
// PARAMETERS
//  DATA_WIDTH  64   codeword width, = packer DATA_WIDTH
//  LEN_WIDTH   64   length field width, = packer LEN_WIDTH
//  OUT_WIDTH   128  packed word width, = packer OUT_WIDTH
//  FIFO_DEPTH  4    output FIFO entries, power of 2, >=4
// PORTS
//  clk          in   1            clock
//  rst          in   1            reset, synchronous, active-high
//  s_valid      in   1            codeword valid
//  s_ready      out  1            codeword accepted when s_valid&s_ready
//  s_code       in   DATA_WIDTH   codeword, right-aligned
//  s_len        in   LEN_WIDTH    codeword bit length, 1..DATA_WIDTH
//  s_last       in   1            final codeword of frame
//  pk_start     out  1            packer start pulse
//  pk_din       out  DATA_WIDTH   packer data
//  pk_len       out  LEN_WIDTH    packer length
//  pk_last      out  1            packer last
//  pk_busy      in   1            packer busy
//  pk_result_ready in 1           packer word valid (1-cycle pulse)
//  pk_dout      in   OUT_WIDTH    packer word
//  pk_len_last  in   $clog2(OUT_WIDTH)  packer fill count
//  m_valid      out  1            packed word valid
//  m_ready      in   1            downstream accept
//  m_data       out  OUT_WIDTH    packed word
//  m_last       out  1            final word of frame
//  m_tail_bits  out  $clog2(OUT_WIDTH)  valid bits in final word (0 when !m_last)
//  word_count   out  32           words pushed this frame
//  bit_count    out  32           codeword bits accepted this frame
//  err_len      out  1            sticky: s_len==0 or s_len>DATA_WIDTH accepted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, counters and err_len cleared.
//  rst mid-frame aborts frame; packer must be reset by the same rst.
//  pk_din/pk_len/pk_last/pk_start registered; pk_din = s_code masked to s_len.
//  States:
//   IDLE  : s_ready=0. s_valid -> ARM; clears word_count/bit_count/err_len.
//   ARM   : pk_start=1 one cycle -> FEED.
//   FEED  : s_ready = !pk_busy & !busy_q & free>=3. Accepted beat drives
//           pk_din/pk_len next cycle; non-accept cycle drives pk_len=0,pk_din=0.
//           busy_q = pk_busy delayed 1 cycle (one idle beat after busy falls).
//           Accepted beat with s_last -> LAST.
//   LAST  : pk_last=1 with final codeword, held 2 cycles (len=0 on 2nd) -> DRAIN.
//   DRAIN : s_ready=0, pk_last=0. First pk_result_ready with pk_busy==0 is the
//           final word: push with m_last=1, m_tail_bits=pk_len_last -> DONE.
//   DONE  : wait FIFO empty -> IDLE.
//  Every pk_result_ready pushes {pk_dout,last,tail} into FIFO; word_count+1.
//  bit_count += s_len per accepted beat, saturating at 2^32-1.
//  FIFO: first-word fall-through, m_data/m_last stable while m_valid&!m_ready.
//  Push to full FIFO cannot occur (free>=3 gate); assert in sim.
//  Overflow+last same beat: two words follow (busy path); both pushed, 2nd m_last.
//  s_len 0 or >DATA_WIDTH: accepted, forwarded as len 0, err_len set.
// TESTING
//  8 codes len=8 OUT_WIDTH=16 -> 4 words, m_last on 4th, tail=0, bit_count=64.
//  3 codes len 5,5,3 -> single m_last word, m_tail_bits=13, word_count=1.
//  Overflow on last code (len 10,10) -> 2 words, m_last only on 2nd, tail=4.
//  m_ready=0 throughout: s_ready drops at free<3, no FIFO overflow, data intact.
//  s_len=0 mid-frame -> err_len=1 sticky until next IDLE->ARM; rst mid-FEED -> all 0.

Source files
------------

// File: rtl/huff_pack_ctrl.sv
// Sequencer for the Huffman bit packer: feeds codewords under the packer's busy/last rules
// and buffers packed words in a fall-through FIFO with end-of-frame tag and tail bit count.
module huff_pack_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 64,
  parameter int OUT_WIDTH  = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_code,
  input  logic [LEN_WIDTH-1:0]          s_len,
  input  logic                          s_last,
  output logic                          pk_start,
  output logic [DATA_WIDTH-1:0]         pk_din,
  output logic [LEN_WIDTH-1:0]          pk_len,
  output logic                          pk_last,
  input  logic                          pk_busy,
  input  logic                          pk_result_ready,
  input  logic [OUT_WIDTH-1:0]          pk_dout,
  input  logic [$clog2(OUT_WIDTH)-1:0]  pk_len_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [OUT_WIDTH-1:0]          m_data,
  output logic                          m_last,
  output logic [$clog2(OUT_WIDTH)-1:0]  m_tail_bits,
  output logic [31:0]                   word_count,
  output logic [31:0]                   bit_count,
  output logic                          err_len
);

  localparam int TW = $clog2(OUT_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = ((LEN_WIDTH > 32) ? LEN_WIDTH : 32) + 1;

  typedef enum logic [2:0] {IDLE, ARM, FEED, LAST, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   last_cnt, last_cnt_nxt;
  logic                   busy_q;
  logic [CW-1:0]          count;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [OUT_WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic                   mem_last [FIFO_DEPTH];
  logic [TW-1:0]          mem_tail [FIFO_DEPTH];

  logic                   accept, len_ok, push, pop, push_last, frame_clr;
  logic [LEN_WIDTH-1:0]   mask_sh;
  logic [DATA_WIDTH-1:0]  code_masked;
  logic                   start_nxt, last_nxt;
  logic [DATA_WIDTH-1:0]  din_nxt;
  logic [LEN_WIDTH-1:0]   len_nxt;
  logic [SW-1:0]          bit_sum;

  assign len_ok      = (s_len != '0) && (s_len <= LEN_WIDTH'(DATA_WIDTH));
  assign mask_sh     = LEN_WIDTH'(DATA_WIDTH) - s_len;
  assign code_masked = len_ok ? (s_code & ({DATA_WIDTH{1'b1}} >> mask_sh)) : '0;
  // Three free slots cover the words that can still land after s_ready drops.
  assign s_ready     = (state == FEED) && !pk_busy && !busy_q && (count <= CW'(FIFO_DEPTH - 3));
  assign accept      = s_valid && s_ready;
  assign push        = pk_result_ready;
  assign pop         = m_valid && m_ready;
  assign bit_sum     = SW'(bit_count) + SW'(s_len);

  always_comb begin
    state_nxt    = state;
    last_cnt_nxt = last_cnt;
    start_nxt    = 1'b0;
    din_nxt      = '0;
    len_nxt      = '0;
    last_nxt     = 1'b0;
    push_last    = 1'b0;
    frame_clr    = 1'b0;
    case (state)
      IDLE: if (s_valid) begin
        state_nxt = ARM;
        frame_clr = 1'b1;
      end
      ARM: begin
        start_nxt = 1'b1;
        state_nxt = FEED;
      end
      FEED: if (accept) begin
        din_nxt = code_masked;
        len_nxt = len_ok ? s_len : '0;
        if (s_last) begin
          last_nxt     = 1'b1;
          last_cnt_nxt = 1'b0;
          state_nxt    = LAST;
        end
      end
      LAST: if (!last_cnt) begin
        last_nxt     = 1'b1;
        last_cnt_nxt = 1'b1;
      end else begin
        state_nxt = DRAIN;
      end
      // A word arriving with busy still high is the overflow word, not the tail.
      DRAIN: if (pk_result_ready && !pk_busy) begin
        push_last = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (count == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_cnt   <= 1'b0;
      busy_q     <= 1'b0;
      pk_start   <= 1'b0;
      pk_din     <= '0;
      pk_len     <= '0;
      pk_last    <= 1'b0;
      word_count <= '0;
      bit_count  <= '0;
      err_len    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_cnt <= last_cnt_nxt;
      busy_q   <= pk_busy;
      pk_start <= start_nxt;
      pk_din   <= din_nxt;
      pk_len   <= len_nxt;
      pk_last  <= last_nxt;
      if (frame_clr) begin
        word_count <= '0;
        bit_count  <= '0;
        err_len    <= 1'b0;
      end else begin
        if (push) word_count <= word_count + 32'd1;
        if (accept) begin
          bit_count <= (bit_sum > SW'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : bit_sum[31:0];
          if (!len_ok) err_len <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
        mem_tail[i] <= '0;
      end
    end else begin
      assert (!(push && !pop && (count == CW'(FIFO_DEPTH))));
      if (push) begin
        mem_data[wr_ptr] <= pk_dout;
        mem_last[wr_ptr] <= push_last;
        mem_tail[wr_ptr] <= push_last ? pk_len_last : '0;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign m_valid     = (count != '0);
  assign m_data      = m_valid ? mem_data[rd_ptr] : '0;
  assign m_last      = m_valid ? mem_last[rd_ptr] : 1'b0;
  assign m_tail_bits = m_valid ? mem_tail[rd_ptr] : '0;

endmodule
